// File: rtl/dbus_pkg.sv
// Shared types and defaults for the two-master data-bus arbiter.
package dbus_pkg;

  localparam int LOCK_MAX_DEFAULT     = 8;
  localparam int STARVE_LIMIT_DEFAULT = 16;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // State is the bus owner of the previous cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_M0   = 2'd1,
    S_M1   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // One master's request, already normalised (read+write collapses to write).
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic state_e owner_to_state(input owner_e owner);
    case (owner)
      OWN_M0:  return S_M0;
      OWN_M1:  return S_M1;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/dbus_arb_grant.sv
// Combinational grant decision: M0 priority, M1 lock retention, and the
// optional starvation override enabled by DBUS_ARB_STARVE_GUARD_EN.
module dbus_arb_grant
  import dbus_pkg::*;
#(
  parameter int p_LOCK_MAX = LOCK_MAX_DEFAULT
`ifdef DBUS_ARB_STARVE_GUARD_EN
  ,
  parameter int p_STARVE_LIMIT = STARVE_LIMIT_DEFAULT
`endif
) (
  input  state_e                              state_i,
  input  logic                                m0_req_i,
  input  logic                                m1_req_i,
  input  logic                                m1_lock_i,
  input  logic [$clog2(p_LOCK_MAX+1)-1:0]     lock_cnt_i,
`ifdef DBUS_ARB_STARVE_GUARD_EN
  input  logic [$clog2(p_STARVE_LIMIT+1)-1:0] starve_cnt_i,
`endif
  output owner_e                              owner_o
);

  localparam int LW = $clog2(p_LOCK_MAX + 1);

  logic lock_hold;
  logic m1_force;

  // Lock only extends an existing M1 tenure; it never pre-empts M0.
  assign lock_hold = (state_i == S_M1) && m1_lock_i &&
                     (lock_cnt_i < LW'(p_LOCK_MAX));

`ifdef DBUS_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(p_STARVE_LIMIT + 1);
  assign m1_force = (starve_cnt_i >= SW'(p_STARVE_LIMIT));
`else
  assign m1_force = 1'b0;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    owner_o = OWN_NONE;
    if (m1_req_i && (!m0_req_i || lock_hold || m1_force)) begin
      owner_o = OWN_M1;
    end else if (m0_req_i) begin
      owner_o = OWN_M0;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master (CPU M0, DMA M1) data-bus arbiter with zero-latency bus mux and
// registered read return. Optional starvation guard: DBUS_ARB_STARVE_GUARD_EN.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int p_LOCK_MAX     = LOCK_MAX_DEFAULT,
  parameter int p_STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [29:0] i_M0_Address,
  input  logic [3:0]  i_M0_ByteEn,
  input  logic        i_M0_Read,
  input  logic        i_M0_Write,
  input  logic [31:0] i_M0_WriteData,
  input  logic [29:0] i_M1_Address,
  input  logic [3:0]  i_M1_ByteEn,
  input  logic        i_M1_Read,
  input  logic        i_M1_Write,
  input  logic [31:0] i_M1_WriteData,
  input  logic        i_M1_Lock,
  output logic        o_M0_Grant,
  output logic        o_M1_Grant,
  output logic [31:0] o_M0_ReadData,
  output logic        o_M0_RdValid,
  output logic [31:0] o_M1_ReadData,
  output logic        o_M1_RdValid,
  output logic [29:0] o_DBus_Address,
  output logic [3:0]  o_DBus_ByteEn,
  output logic        o_DBus_Read,
  output logic        o_DBus_Write,
  output logic [31:0] o_DBus_WriteData,
  input  logic [31:0] i_DBus_ReadData
);

  localparam int LW = $clog2(p_LOCK_MAX + 1);

  state_e        state_q, state_d;
  owner_e        owner_raw, owner;
  owner_e        rd_owner_q, rd_owner_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  bus_req_t      m0_req, m1_req, bus;
  logic          m0_active, m1_active;

  assign m0_req = '{addr:  i_M0_Address,
                    be:    i_M0_ByteEn,
                    rd:    i_M0_Read & ~i_M0_Write,
                    wr:    i_M0_Write,
                    wdata: i_M0_WriteData};
  assign m1_req = '{addr:  i_M1_Address,
                    be:    i_M1_ByteEn,
                    rd:    i_M1_Read & ~i_M1_Write,
                    wr:    i_M1_Write,
                    wdata: i_M1_WriteData};

  assign m0_active = m0_req.rd | m0_req.wr;
  assign m1_active = m1_req.rd | m1_req.wr;

`ifdef DBUS_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(p_STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
`endif

  dbus_arb_grant #(
    .p_LOCK_MAX     (p_LOCK_MAX)
`ifdef DBUS_ARB_STARVE_GUARD_EN
    ,
    .p_STARVE_LIMIT (p_STARVE_LIMIT)
`endif
  ) u_grant (
    .state_i      (state_q),
    .m0_req_i     (m0_active),
    .m1_req_i     (m1_active),
    .m1_lock_i    (i_M1_Lock),
    .lock_cnt_i   (lock_cnt_q),
`ifdef DBUS_ARB_STARVE_GUARD_EN
    .starve_cnt_i (starve_cnt_q),
`endif
    .owner_o      (owner_raw)
  );

  // Reset must silence the bus even while masters keep requesting.
  assign owner = i_Rst_n ? owner_raw : OWN_NONE;

  always_comb begin
    state_d    = owner_to_state(owner);
    rd_owner_d = OWN_NONE;
    lock_cnt_d = '0;
    if (owner == OWN_M0 && m0_req.rd) begin
      rd_owner_d = OWN_M0;
    end else if (owner == OWN_M1 && m1_req.rd) begin
      rd_owner_d = OWN_M1;
    end
    // Saturate so a lone locked M1 cannot wrap and regain a fresh budget.
    if (owner == OWN_M1 && state_q == S_M1 && i_M1_Lock) begin
      lock_cnt_d = (lock_cnt_q == LW'(p_LOCK_MAX)) ? lock_cnt_q
                                                    : lock_cnt_q + LW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      rd_owner_q <= OWN_NONE;
      lock_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

`ifdef DBUS_ARB_STARVE_GUARD_EN
  always_comb begin
    starve_cnt_d = '0;
    if (m1_active && owner != OWN_M1) begin
      starve_cnt_d = (starve_cnt_q == SW'(p_STARVE_LIMIT)) ? starve_cnt_q
                                                            : starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  always_comb begin
    case (owner)
      OWN_M0:  bus = m0_req;
      OWN_M1:  bus = m1_req;
      default: bus = '0;
    endcase
  end

  assign o_DBus_Address   = bus.addr;
  assign o_DBus_ByteEn    = bus.be;
  assign o_DBus_Read      = bus.rd;
  assign o_DBus_Write     = bus.wr;
  assign o_DBus_WriteData = bus.wdata;

  assign o_M0_Grant    = (owner == OWN_M0);
  assign o_M1_Grant    = (owner == OWN_M1);
  assign o_M0_RdValid  = (rd_owner_q == OWN_M0);
  assign o_M1_RdValid  = (rd_owner_q == OWN_M1);
  assign o_M0_ReadData = o_M0_RdValid ? i_DBus_ReadData : '0;
  assign o_M1_ReadData = o_M1_RdValid ? i_DBus_ReadData : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed self-checking bench for dbus_arbiter (default parameters).
module tb_dbus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [29:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic        m0_rd, m0_wr, m1_rd, m1_wr, m1_lock;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rv, m1_rv;
  logic [31:0] m0_rdata, m1_rdata;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_wdata, bus_rdata;

  int n_checks;
  int n_fail;

  dbus_arbiter dut (
    .i_Clk            (clk),
    .i_Rst_n          (rst_n),
    .i_M0_Address     (m0_addr),
    .i_M0_ByteEn      (m0_be),
    .i_M0_Read        (m0_rd),
    .i_M0_Write       (m0_wr),
    .i_M0_WriteData   (m0_wdata),
    .i_M1_Address     (m1_addr),
    .i_M1_ByteEn      (m1_be),
    .i_M1_Read        (m1_rd),
    .i_M1_Write       (m1_wr),
    .i_M1_WriteData   (m1_wdata),
    .i_M1_Lock        (m1_lock),
    .o_M0_Grant       (m0_gnt),
    .o_M1_Grant       (m1_gnt),
    .o_M0_ReadData    (m0_rdata),
    .o_M0_RdValid     (m0_rv),
    .o_M1_ReadData    (m1_rdata),
    .o_M1_RdValid     (m1_rv),
    .o_DBus_Address   (bus_addr),
    .o_DBus_ByteEn    (bus_be),
    .o_DBus_Read      (bus_rd),
    .o_DBus_Write     (bus_wr),
    .o_DBus_WriteData (bus_wdata),
    .i_DBus_ReadData  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_rd = 0; m0_wr = 0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
    m1_rd = 0; m1_wr = 0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
    m1_lock = 0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    m0_rd = 1; m0_addr = 30'h11; m0_be = 4'hF;
    m1_wr = 1; m1_addr = 30'h22; m1_be = 4'hF; m1_wdata = 32'h5555_AAAA;
    bus_rdata = 32'h1111_2222;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_grants: got m0=%b m1=%b expected 0 0", m0_gnt, m1_gnt); end
      n_checks++; if (bus_rd !== 1'b0 || bus_wr !== 1'b0 || bus_be !== 4'h0) begin n_fail++; $display("FAIL reset_strobes: got rd=%b wr=%b be=%h expected 0 0 0", bus_rd, bus_wr, bus_be); end
      n_checks++; if (m0_rv !== 1'b0 || m1_rv !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdvalid: got rv=%b%b rdata=%h/%h expected 00 0/0", m0_rv, m1_rv, m0_rdata, m1_rdata); end
      tick();
    end
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    tick();
    n_checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || bus_addr !== 30'h0 || bus_wdata !== 32'h0) begin n_fail++; $display("FAIL idle_after_reset: got gnt=%b%b addr=%h wdata=%h expected 00 0 0", m0_gnt, m1_gnt, bus_addr, bus_wdata); end
  endtask

  task automatic test_same_cycle();
    tick();
    m0_rd = 1; m0_addr = 30'h100; m0_be = 4'hF;
    m1_wr = 1; m1_addr = 30'h200; m1_be = 4'h3; m1_wdata = 32'hA5A5_0001;
    #1;
    n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL same_cycle_grant: got m0=%b m1=%b expected 1 0", m0_gnt, m1_gnt); end
    n_checks++; if (bus_addr !== 30'h100 || bus_rd !== 1'b1 || bus_wr !== 1'b0 || bus_be !== 4'hF) begin n_fail++; $display("FAIL same_cycle_m0_bus: got addr=%h rd=%b wr=%b be=%h expected 100 1 0 f", bus_addr, bus_rd, bus_wr, bus_be); end
    tick();
    m0_rd = 0; m0_addr = '0; m0_be = '0;
    bus_rdata = 32'h1234_5678;
    #1;
    n_checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL second_cycle_grant: got m0=%b m1=%b expected 0 1", m0_gnt, m1_gnt); end
    n_checks++; if (bus_wr !== 1'b1 || bus_rd !== 1'b0 || bus_addr !== 30'h200 || bus_wdata !== 32'hA5A5_0001 || bus_be !== 4'h3) begin n_fail++; $display("FAIL m1_write_bus: got wr=%b rd=%b addr=%h wdata=%h be=%h expected 1 0 200 a5a50001 3", bus_wr, bus_rd, bus_addr, bus_wdata, bus_be); end
    n_checks++; if (m0_rv !== 1'b1 || m0_rdata !== 32'h1234_5678 || m1_rv !== 1'b0 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL m0_read_return: got rv=%b%b rdata=%h/%h expected 1 0 12345678/0", m0_rv, m1_rv, m0_rdata, m1_rdata); end
    tick();
    idle_inputs();
    bus_rdata = 32'h9999_0000;
    #1;
    n_checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || m0_rv !== 1'b0 || m1_rv !== 1'b0) begin n_fail++; $display("FAIL after_write_idle: got gnt=%b%b rv=%b%b expected 00 00", m0_gnt, m1_gnt, m0_rv, m1_rv); end
  endtask

  task automatic test_m1_read();
    tick();
    m1_rd = 1; m1_addr = 30'h55; m1_be = 4'hC;
    #1;
    n_checks++; if (m1_gnt !== 1'b1 || bus_rd !== 1'b1 || bus_addr !== 30'h55 || bus_be !== 4'hC) begin n_fail++; $display("FAIL m1_read_grant: got gnt=%b rd=%b addr=%h be=%h expected 1 1 55 c", m1_gnt, bus_rd, bus_addr, bus_be); end
    tick();
    idle_inputs();
    bus_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (m1_rv !== 1'b1 || m1_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL m1_read_return: got rv=%b rdata=%h expected 1 deadbeef", m1_rv, m1_rdata); end
    n_checks++; if (m0_rv !== 1'b0 || m0_rdata !== 32'h0) begin n_fail++; $display("FAIL m1_read_other: got m0 rv=%b rdata=%h expected 0 0", m0_rv, m0_rdata); end
  endtask

  task automatic test_rw_as_write();
    tick();
    m0_rd = 1; m0_wr = 1; m0_addr = 30'h3AB; m0_be = 4'h1; m0_wdata = 32'h0BAD_F00D;
    #1;
    n_checks++; if (m0_gnt !== 1'b1 || bus_wr !== 1'b1 || bus_rd !== 1'b0 || bus_wdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rw_as_write: got gnt=%b wr=%b rd=%b wdata=%h expected 1 1 0 0badf00d", m0_gnt, bus_wr, bus_rd, bus_wdata); end
    tick();
    idle_inputs();
    bus_rdata = 32'h7777_7777;
    #1;
    n_checks++; if (m0_rv !== 1'b0 || m0_rdata !== 32'h0) begin n_fail++; $display("FAIL rw_no_rdvalid: got rv=%b rdata=%h expected 0 0", m0_rv, m0_rdata); end
  endtask

  task automatic test_lock();
    logic exp_m1;
    tick();
    m0_rd = 1; m0_addr = 30'h10; m0_be = 4'hF;
    m1_wr = 1; m1_addr = 30'h20; m1_be = 4'hF; m1_wdata = 32'h0000_0020; m1_lock = 1;
    #1;
    n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_from_idle: got m0=%b m1=%b expected 1 0", m0_gnt, m1_gnt); end
    tick();
    n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_from_m0: got m0=%b m1=%b expected 1 0", m0_gnt, m1_gnt); end
    // Cycle 0 is M1's entry with M0 quiet; M0 re-requests from cycle 1 on.
    for (int i = 0; i < 12; i++) begin
      tick();
      m0_rd = (i != 0);
      #1;
      exp_m1 = (i <= 8);
      n_checks++; if (m1_gnt !== exp_m1 || m0_gnt !== !exp_m1) begin n_fail++; $display("FAIL lock_burst[%0d]: got m0=%b m1=%b expected %b %b", i, m0_gnt, m1_gnt, !exp_m1, exp_m1); end
      if (i == 10) begin
        n_checks++; if (m0_rv !== 1'b1) begin n_fail++; $display("FAIL lock_m0_rdvalid: got %b expected 1", m0_rv); end
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_starve();
    logic exp_m1;
    int   m1_count;
    m1_count = 0;
    tick();
    m0_rd = 1; m0_addr = 30'h44; m0_be = 4'hF;
    m1_rd = 1; m1_addr = 30'h88; m1_be = 4'hF;
    for (int i = 0; i < 40; i++) begin
      #1;
`ifdef DBUS_ARB_STARVE_GUARD_EN
      exp_m1 = ((i % 17) == 16);
`else
      exp_m1 = 1'b0;
`endif
      if (m1_gnt === 1'b1) m1_count++;
      n_checks++; if (m1_gnt !== exp_m1 || m0_gnt !== !exp_m1) begin n_fail++; $display("FAIL starve[%0d]: got m0=%b m1=%b expected %b %b", i, m0_gnt, m1_gnt, !exp_m1, exp_m1); end
      tick();
    end
`ifdef DBUS_ARB_STARVE_GUARD_EN
    n_checks++; if (m1_count != 2) begin n_fail++; $display("FAIL starve_count: got %0d expected 2", m1_count); end
`else
    n_checks++; if (m1_count != 0) begin n_fail++; $display("FAIL starve_count: got %0d expected 0", m1_count); end
`endif
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    tick();
    m0_rd = 1; m0_addr = 30'h3C; m0_be = 4'hF;
    #1;
    n_checks++; if (m0_gnt !== 1'b1 || bus_rd !== 1'b1) begin n_fail++; $display("FAIL midrst_grant: got gnt=%b rd=%b expected 1 1", m0_gnt, bus_rd); end
    @(negedge clk);
    rst_n = 0;
    #1;
    n_checks++; if (m0_gnt !== 1'b0 || bus_rd !== 1'b0 || bus_wr !== 1'b0) begin n_fail++; $display("FAIL midrst_strobes: got gnt=%b rd=%b wr=%b expected 0 0 0", m0_gnt, bus_rd, bus_wr); end
    tick();
    bus_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if (m0_rv !== 1'b0 || m0_rdata !== 32'h0 || bus_rd !== 1'b0 || bus_wr !== 1'b0) begin n_fail++; $display("FAIL midrst_rdvalid: got rv=%b rdata=%h rd=%b wr=%b expected 0 0 0 0", m0_rv, m0_rdata, bus_rd, bus_wr); end
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    tick();
    n_checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || m0_rv !== 1'b0 || m1_rv !== 1'b0) begin n_fail++; $display("FAIL midrst_release_idle: got gnt=%b%b rv=%b%b expected 00 00", m0_gnt, m1_gnt, m0_rv, m1_rv); end
    tick();
    m0_rd = 1; m0_addr = 30'h7; m0_be = 4'hF;
    m1_wr = 1; m1_addr = 30'h9; m1_be = 4'hF; m1_lock = 1;
    #1;
    n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || bus_addr !== 30'h7) begin n_fail++; $display("FAIL midrst_first_grant: got m0=%b m1=%b addr=%h expected 1 0 7", m0_gnt, m1_gnt, bus_addr); end
    tick();
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_same_cycle();
    test_m1_read();
    test_rw_as_write();
    test_lock();
    test_starve();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter p_LOCK_MAX, default 8, meaning the maximum consecutive cycles M1 may hold the bus under lock.
REQ-002 SHALL have parameter p_STARVE_LIMIT, default 16, meaning the consecutive denied M1 request cycles before a forced M1 grant.
REQ-003 SHALL have port i_Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports i_M0_Address / i_M1_Address, input, 30 bits: word address from the CPU (M0) and DMA (M1) masters.
REQ-006 SHALL have ports i_M0_ByteEn / i_M1_ByteEn, input, 4 bits: byte lanes.
REQ-007 SHALL have ports i_M0_Read, i_M0_Write, i_M1_Read, i_M1_Write, input, 1 bit each: request strobes.
REQ-008 SHALL have ports i_M0_WriteData / i_M1_WriteData, input, 32 bits: write data.
REQ-009 SHALL have port i_M1_Lock, input, 1 bit: M1 requests retention of ownership across back-to-back accesses.
REQ-010 SHALL have ports o_M0_Grant / o_M1_Grant, output, 1 bit: the master's access is accepted this cycle.
REQ-011 SHALL have ports o_M0_ReadData / o_M1_ReadData, output, 32 bits, and o_M0_RdValid / o_M1_RdValid, output, 1 bit: returned read data.
REQ-012 SHALL have ports o_DBus_Address (30), o_DBus_ByteEn (4), o_DBus_Read (1), o_DBus_Write (1), o_DBus_WriteData (32) as outputs, and i_DBus_ReadData (32) as input: the shared data bus.

Function
- REQ-013 A master requests when its Read or Write is high; Read and Write together SHALL be treated as Write.
- REQ-014 The FSM SHALL have states S_IDLE, S_M0, S_M1, where the state is the owner of the previous cycle.
- REQ-015 Grant decision, combinational from requests and state:
  - M0 wins, except in S_M1 with i_M1_Lock high, M1 requesting and lock counter < p_LOCK_MAX, where M1 wins.
  - M1 alone requesting wins.
  - No request leads to S_IDLE.
- REQ-016 o_DBus_* SHALL combinationally mux the granted master's signals with zero latency; when no grant, Read=Write=0, ByteEn=4'b0000, Address and WriteData=0.
- REQ-017 At most one Grant SHALL be high per cycle; Grant SHALL be high only when that master requests.
- REQ-018 Read data return:
  - A granted read in cycle N SHALL produce RdValid=1 for that master in cycle N+1, with ReadData=i_DBus_ReadData, using a registered read-owner.
  - The other master's ReadData SHALL be 0.
- REQ-019 Lock counter:
  - SHALL increment each cycle M1 is granted while in S_M1 with i_M1_Lock=1, and clear otherwise.
  - On reaching p_LOCK_MAX with M0 requesting, M0 SHALL be granted for at least one cycle.
- REQ-020 Lock SHALL be ignored when entering from S_IDLE or S_M0; it only retains ownership, never pre-empts.
- REQ-021 A denied master SHALL hold its request stable until granted; the arbiter SHALL NOT queue requests.

Reset
- REQ-022 While i_Rst_n=0:
  - state=S_IDLE;
  - lock and starvation counters=0;
  - read-owner=none;
  - Grants=0, RdValid=0, ReadData=0;
  - bus strobes=0 regardless of requests.
- REQ-023 A reset asserted mid-read SHALL suppress the pending RdValid; the first grant after deassertion SHALL follow REQ-015 from S_IDLE.

Configuration
- REQ-024 Macro DBUS_ARB_STARVE_GUARD_EN defined:
  - a counter SHALL count consecutive cycles with M1 requesting and not granted;
  - at p_STARVE_LIMIT, M1 SHALL be granted for one cycle over M0;
  - the counter SHALL clear on M1 grant.
- REQ-025 Macro undefined: no starvation counter SHALL exist, and M0 priority is absolute except under REQ-015 lock.

Structure
- REQ-026 The FSM state encoding, the owner encoding (NONE/M0/M1) and the default parameter values SHALL live in shared package dbus_pkg.
- REQ-027 The grant logic SHALL be a single sub-module, dbus_arb_grant (combinational priority/lock/starve decision); datapath muxing and registers SHALL stay in dbus_arbiter.

Verification
- REQ-028 M0 read 0x100 and M1 write 0x200 in the same cycle -> o_M0_Grant=1, o_DBus_Address=0x100, o_DBus_Read=1; next cycle M1 granted, o_DBus_Write=1, o_DBus_WriteData=M1 data.
- REQ-029 M1 read granted with i_DBus_ReadData=0xDEADBEEF next cycle -> o_M1_RdValid=1, o_M1_ReadData=0xDEADBEEF, o_M0_RdValid=0.
- REQ-030 M1 locked burst with M0 requesting continuously, p_LOCK_MAX=8 -> M1 granted 9 cycles (entry + 8), then M0 granted.
- REQ-031 With DBUS_ARB_STARVE_GUARD_EN and M0 and M1 requesting constantly, p_STARVE_LIMIT=16 -> M1 granted exactly once every 17 cycles; without the macro, M1 is never granted.
- REQ-032 i_Rst_n pulled low one cycle after an M0 read grant -> o_M0_RdValid stays 0, all bus strobes 0; after release, idle requests -> no grant.
